// File: rtl/writeback_sequencer_pkg.sv
// Shared encodings for the register-file write-back sequencer.
//   - wb_kind request encodings (6..7 reserved)
//   - WriteRegCtrl destination select codes
//   - wb_src write-data source codes
//   - FSM state encoding
package writeback_sequencer_pkg;

    // Request kinds
    localparam logic [2:0] KIND_RTYPE = 3'd0;
    localparam logic [2:0] KIND_ITYPE = 3'd1;
    localparam logic [2:0] KIND_LOAD  = 3'd2;
    localparam logic [2:0] KIND_JAL   = 3'd3;
    localparam logic [2:0] KIND_PUSH  = 3'd4;
    localparam logic [2:0] KIND_POP   = 3'd5;

    // WriteRegMux destination select
    localparam logic [1:0] WR_RD   = 2'b00;  // rd[15:11]
    localparam logic [1:0] WR_SP29 = 2'b01;  // $29
    localparam logic [1:0] WR_RA31 = 2'b10;  // $31
    localparam logic [1:0] WR_RT   = 2'b11;  // rt[20:16]

    // Write-data source select
    localparam logic [1:0] SRC_ALU    = 2'b00;
    localparam logic [1:0] SRC_MEM    = 2'b01;
    localparam logic [1:0] SRC_PC4    = 2'b10;
    localparam logic [1:0] SRC_SP_ADJ = 2'b11;

    // FSM states
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_WRITE1   = 2'd2;
    localparam logic [1:0] ST_WRITE2   = 2'd3;

    function automatic logic kind_valid(input logic [2:0] kind);
        return kind <= KIND_POP;
    endfunction

endpackage

// File: rtl/wb_lat_counter.sv
// Loadable down-counter with zero flag, used to time memory data phases.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   clr_i          - synchronous clear to 0 (highest priority)
//   load_i         - load load_val_i
//   load_val_i     - value to load
//   dec_i          - decrement by one; saturates at 0 so it never wraps
//   zero_o         - counter equals 0
module wb_lat_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_d;
    logic [Width-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/writeback_sequencer.sv
// Multicycle register-file write-back controller.
// Accepts one request per instruction (wb_req/wb_kind, sampled only in IDLE) and
// sequences WriteRegCtrl, RegWrite, wb_src/sp_inc and the memory strobes, including
// memory waits (LOAD/POP/PUSH) and the second $sp write of POP / first of PUSH.
// Ports:
//   clk, reset (async, active-low)
//   wb_req, wb_kind, flush           - request and synchronous abort
//   WriteRegCtrl, RegWrite           - to WriteRegMux / register file
//   wb_src, sp_inc                   - write-data mux select, $sp adjust direction
//   mem_rd, mem_wr                   - memory strobes during the data phase
//   busy, done, bad_kind             - status
// All outputs decode registered state only.
module writeback_sequencer
    import writeback_sequencer_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_req,
    input  logic [2:0] wb_kind,
    input  logic       flush,
    output logic [1:0] WriteRegCtrl,
    output logic       RegWrite,
    output logic [1:0] wb_src,
    output logic       sp_inc,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       busy,
    output logic       done,
    output logic       bad_kind
);

    localparam logic [CNT_W-1:0] LatLoad = CNT_W'(MEM_LAT - 1);

    logic [1:0] state_d, state_q;
    logic [2:0] kind_d, kind_q;
    logic       bad_kind_d, bad_kind_q;
    logic       cnt_load, cnt_dec, cnt_zero;

    wb_lat_counter #(
        .Width (CNT_W)
    ) u_lat_counter (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clr_i      (flush),
        .load_i     (cnt_load),
        .load_val_i (LatLoad),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        bad_kind_d = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (wb_req) begin
                        if (kind_valid(wb_kind)) begin
                            kind_d = wb_kind;
                            if (wb_kind == KIND_LOAD || wb_kind == KIND_POP) begin
                                state_d  = ST_MEM_WAIT;
                                cnt_load = 1'b1;
                            end else begin
                                state_d = ST_WRITE1;
                            end
                        end else begin
                            bad_kind_d = 1'b1;
                        end
                    end
                end
                ST_WRITE1: begin
                    if (kind_q == KIND_PUSH) begin
                        // $sp has been decremented; now the store data phase
                        state_d  = ST_MEM_WAIT;
                        cnt_load = 1'b1;
                    end else if (kind_q == KIND_POP) begin
                        state_d = ST_WRITE2;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MEM_WAIT: begin
                    if (cnt_zero) begin
                        state_d = (kind_q == KIND_PUSH) ? ST_IDLE : ST_WRITE1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_WRITE2: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            kind_q     <= KIND_RTYPE;
            bad_kind_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            bad_kind_q <= bad_kind_d;
        end
    end

    // Moore output decode
    always_comb begin
        WriteRegCtrl = WR_RD;
        RegWrite     = 1'b0;
        wb_src       = SRC_ALU;
        sp_inc       = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        done         = 1'b0;
        busy         = (state_q != ST_IDLE);
        bad_kind     = bad_kind_q;
        unique case (state_q)
            ST_WRITE1: begin
                RegWrite = 1'b1;
                done     = 1'b1;
                unique case (kind_q)
                    KIND_ITYPE: WriteRegCtrl = WR_RT;
                    KIND_JAL: begin
                        WriteRegCtrl = WR_RA31;
                        wb_src       = SRC_PC4;
                    end
                    KIND_LOAD: begin
                        WriteRegCtrl = WR_RT;
                        wb_src       = SRC_MEM;
                    end
                    KIND_POP: begin
                        WriteRegCtrl = WR_RT;
                        wb_src       = SRC_MEM;
                        done         = 1'b0;
                    end
                    KIND_PUSH: begin
                        WriteRegCtrl = WR_SP29;
                        wb_src       = SRC_SP_ADJ;
                        done         = 1'b0;
                    end
                    default: WriteRegCtrl = WR_RD;
                endcase
            end
            ST_WRITE2: begin
                WriteRegCtrl = WR_SP29;
                RegWrite     = 1'b1;
                wb_src       = SRC_SP_ADJ;
                sp_inc       = 1'b1;
                done         = 1'b1;
            end
            ST_MEM_WAIT: begin
                mem_wr = (kind_q == KIND_PUSH);
                mem_rd = (kind_q != KIND_PUSH);
                done   = (kind_q == KIND_PUSH) && cnt_zero;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed self-checking bench for writeback_sequencer (MEM_LAT = 2).
// Observed outputs are packed as:
//   {WriteRegCtrl[1:0], RegWrite, wb_src[1:0], sp_inc, mem_rd, mem_wr, busy, done, bad_kind}
module tb_writeback_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       wb_req;
    logic [2:0] wb_kind;
    logic       flush;
    logic [1:0] WriteRegCtrl;
    logic       RegWrite;
    logic [1:0] wb_src;
    logic       sp_inc;
    logic       mem_rd;
    logic       mem_wr;
    logic       busy;
    logic       done;
    logic       bad_kind;

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] obs;
    assign obs = {WriteRegCtrl, RegWrite, wb_src, sp_inc, mem_rd, mem_wr, busy, done, bad_kind};

    //                               CC_R_SS_P_RW_B_D_K
    localparam logic [10:0] E_IDLE  = 11'b00_0_00_0_00_0_0_0;
    localparam logic [10:0] E_RTYPE = 11'b00_1_00_0_00_1_1_0;
    localparam logic [10:0] E_ITYPE = 11'b11_1_00_0_00_1_1_0;
    localparam logic [10:0] E_JAL   = 11'b10_1_10_0_00_1_1_0;
    localparam logic [10:0] E_RDW   = 11'b00_0_00_0_10_1_0_0;
    localparam logic [10:0] E_LDW   = 11'b11_1_01_0_00_1_1_0;
    localparam logic [10:0] E_POPW1 = 11'b11_1_01_0_00_1_0_0;
    localparam logic [10:0] E_POPW2 = 11'b01_1_11_1_00_1_1_0;
    localparam logic [10:0] E_PSHW1 = 11'b01_1_11_0_00_1_0_0;
    localparam logic [10:0] E_WRW   = 11'b00_0_00_0_01_1_0_0;
    localparam logic [10:0] E_WRWD  = 11'b00_0_00_0_01_1_1_0;
    localparam logic [10:0] E_BAD   = 11'b00_0_00_0_00_0_0_1;

    writeback_sequencer #(
        .MEM_LAT (2),
        .CNT_W   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_req       (wb_req),
        .wb_kind      (wb_kind),
        .flush        (flush),
        .WriteRegCtrl (WriteRegCtrl),
        .RegWrite     (RegWrite),
        .wb_src       (wb_src),
        .sp_inc       (sp_inc),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .busy         (busy),
        .done         (done),
        .bad_kind     (bad_kind)
    );

    always #5 clk = ~clk;

    // Advance one cycle; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle request; returns in the cycle after acceptance.
    task automatic req(input logic [2:0] k);
        wb_req  = 1'b1;
        wb_kind = k;
        tick();
        wb_req  = 1'b0;
        wb_kind = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        n_tests++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL reset_init: got %b want %b", obs, E_IDLE);
        end
        reset = 1'b1;
        tick();
        // Reset asserted mid-POP while in the memory wait
        req(3'd5);
        n_tests++;
        if (obs !== E_RDW) begin
            n_fail++;
            $display("FAIL reset_pop_wait: got %b want %b", obs, E_RDW);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL reset_async: got %b want %b", obs, E_IDLE);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (obs !== E_IDLE) begin
                n_fail++;
                $display("FAIL reset_release_c%0d: got %b want %b", i, obs, E_IDLE);
            end
        end
    endtask

    task automatic test_rtype();
        req(3'd0);
        n_tests++;
        if (obs !== E_RTYPE) begin
            n_fail++;
            $display("FAIL rtype_write: got %b want %b", obs, E_RTYPE);
        end
        tick();
        n_tests++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL rtype_idle: got %b want %b", obs, E_IDLE);
        end
    endtask

    // ITYPE issued in the IDLE cycle right after done, then JAL right after that
    task automatic test_back_to_back();
        req(3'd1);
        n_tests++;
        if (obs !== E_ITYPE) begin
            n_fail++;
            $display("FAIL itype_write: got %b want %b", obs, E_ITYPE);
        end
        tick();
        req(3'd3);
        n_tests++;
        if (obs !== E_JAL) begin
            n_fail++;
            $display("FAIL jal_write: got %b want %b", obs, E_JAL);
        end
        tick();
        n_tests++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL jal_idle: got %b want %b", obs, E_IDLE);
        end
    endtask

    task automatic test_load();
        logic [10:0] exp_seq [4];
        exp_seq[0] = E_RDW;
        exp_seq[1] = E_RDW;
        exp_seq[2] = E_LDW;
        exp_seq[3] = E_IDLE;
        req(3'd2);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (obs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL load_c%0d: got %b want %b", i, obs, exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_pop();
        logic [10:0] exp_seq [5];
        int          rw_cnt;
        exp_seq[0] = E_RDW;
        exp_seq[1] = E_RDW;
        exp_seq[2] = E_POPW1;
        exp_seq[3] = E_POPW2;
        exp_seq[4] = E_IDLE;
        rw_cnt = 0;
        req(3'd5);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (obs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL pop_c%0d: got %b want %b", i, obs, exp_seq[i]);
            end
            if (RegWrite === 1'b1) rw_cnt++;
            tick();
        end
        n_tests++;
        if (rw_cnt != 2) begin
            n_fail++;
            $display("FAIL pop_regwrite_count: got %0d want 2", rw_cnt);
        end
    endtask

    task automatic test_push();
        logic [10:0] exp_seq [4];
        exp_seq[0] = E_PSHW1;
        exp_seq[1] = E_WRW;
        exp_seq[2] = E_WRWD;
        exp_seq[3] = E_IDLE;
        req(3'd4);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (obs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL push_c%0d: got %b want %b", i, obs, exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        int done_cnt;
        done_cnt = 0;
        req(3'd4);
        n_tests++;
        if (obs !== E_PSHW1) begin
            n_fail++;
            $display("FAIL flush_push_w1: got %b want %b", obs, E_PSHW1);
        end
        tick();
        n_tests++;
        if (obs !== E_WRW) begin
            n_fail++;
            $display("FAIL flush_push_wait: got %b want %b", obs, E_WRW);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL flush_idle: got %b want %b", obs, E_IDLE);
        end
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1 || RegWrite === 1'b1) done_cnt++;
            tick();
        end
        n_tests++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL flush_no_done: got %0d want 0", done_cnt);
        end
        // flush wins over a request presented in IDLE
        flush = 1'b1;
        req(3'd0);
        flush = 1'b0;
        n_tests++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL flush_priority: got %b want %b", obs, E_IDLE);
        end
        tick();
        // Flush mid-LOAD clears the counter: a following LOAD takes full latency
        req(3'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req(3'd2);
        n_tests++;
        if (obs !== E_RDW) begin
            n_fail++;
            $display("FAIL flush_reload_c0: got %b want %b", obs, E_RDW);
        end
        tick();
        n_tests++;
        if (obs !== E_RDW) begin
            n_fail++;
            $display("FAIL flush_reload_c1: got %b want %b", obs, E_RDW);
        end
        tick();
        n_tests++;
        if (obs !== E_LDW) begin
            n_fail++;
            $display("FAIL flush_reload_w: got %b want %b", obs, E_LDW);
        end
        tick();
    endtask

    task automatic test_bad_kind();
        req(3'd6);
        n_tests++;
        if (obs !== E_BAD) begin
            n_fail++;
            $display("FAIL bad_kind6: got %b want %b", obs, E_BAD);
        end
        tick();
        n_tests++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL bad_kind_pulse: got %b want %b", obs, E_IDLE);
        end
        req(3'd7);
        n_tests++;
        if (obs !== E_BAD) begin
            n_fail++;
            $display("FAIL bad_kind7: got %b want %b", obs, E_BAD);
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        int done_cnt;
        done_cnt = 0;
        req(3'd2);
        // Hammer requests through the whole memory wait
        wb_req  = 1'b1;
        wb_kind = 3'd0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (obs !== E_RDW) begin
                n_fail++;
                $display("FAIL busy_ignore_wait_c%0d: got %b want %b", i, obs, E_RDW);
            end
            tick();
        end
        wb_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) done_cnt++;
            tick();
        end
        n_tests++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL busy_ignore_done_count: got %0d want 1", done_cnt);
        end
        n_tests++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL busy_ignore_idle: got %b want %b", obs, E_IDLE);
        end
    endtask

    initial begin
        reset   = 1'b0;
        wb_req  = 1'b0;
        wb_kind = 3'd0;
        flush   = 1'b0;
        test_reset();
        test_rtype();
        test_back_to_back();
        test_load();
        test_pop();
        test_push();
        test_flush();
        test_bad_kind();
        test_busy_ignore();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
